// File: rtl/unidad_mul_div_if.sv
// unidad_mul_div_if: start/busy/done bundle of the multiply/divide unit.
// master drives the request, slave returns results and flags.
interface unidad_mul_div_if #(
  parameter int ancho = 32
);
  logic             inicio;
  logic [1:0]       operacion;
  logic [ancho-1:0] operandoA;
  logic [ancho-1:0] operandoB;
  logic [ancho-1:0] resultado;
  logic [ancho-1:0] resultado_alto;
  logic             carryOut;
  logic             borrowOut;
  logic             overflow;
  logic             ocupado;
  logic             listo;

  modport master (
    output inicio, operacion, operandoA, operandoB,
    input  resultado, resultado_alto, carryOut,
    input  borrowOut, overflow, ocupado, listo
  );

  modport slave (
    input  inicio, operacion, operandoA, operandoB,
    output resultado, resultado_alto, carryOut,
    output borrowOut, overflow, ocupado, listo
  );
endinterface

// File: rtl/unidad_mul_div.sv
// unidad_mul_div: one-bit-per-clock shift-add multiply / restoring divide.
// Define MULDIV_SIGNED_EN to make codes 10/11 signed (MULS/DIVS).
module unidad_mul_div #(
  parameter int ancho = 32
) (
  input logic              clk,
  input logic              reset_n,
  unidad_mul_div_if.slave  bus
);
  localparam int CW = $clog2(ancho);
  localparam logic [CW-1:0] LAST = CW'(ancho - 1);
  localparam logic [ancho-1:0] MIN_NEG = {1'b1, {(ancho-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             is_div;
  logic [ancho-1:0] m;
  logic [ancho-1:0] hi;
  logic [ancho-1:0] lo;
`ifdef MULDIV_SIGNED_EN
  logic             is_sgn;
  logic             neg_q;
  logic             neg_r;
  logic             ovf_div;
`endif

  logic             sgn_in;
  logic             a_neg;
  logic             b_neg;
  logic [ancho-1:0] a_mag;
  logic [ancho-1:0] b_mag;

  always_comb begin
`ifdef MULDIV_SIGNED_EN
    sgn_in = bus.operacion[1];
`else
    sgn_in = 1'b0;
`endif
    a_neg = sgn_in & bus.operandoA[ancho-1];
    b_neg = sgn_in & bus.operandoB[ancho-1];
    a_mag = a_neg ? -bus.operandoA : bus.operandoA;
    b_mag = b_neg ? -bus.operandoB : bus.operandoB;
  end

  // hi:lo is product accumulator for MUL, remainder:quotient for DIV
  logic [ancho:0]   sum;
  logic [ancho:0]   sh;
  logic [ancho:0]   diff;
  logic [ancho-1:0] hi_nx;
  logic [ancho-1:0] lo_nx;

  always_comb begin
    sum   = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
    sh    = {hi, lo[ancho-1]};
    diff  = sh - {1'b0, m};
    hi_nx = sum[ancho:1];
    lo_nx = {sum[0], lo[ancho-1:1]};
    if (is_div) begin
      if (!diff[ancho]) begin
        hi_nx = diff[ancho-1:0];
        lo_nx = {lo[ancho-2:0], 1'b1};
      end else begin
        hi_nx = sh[ancho-1:0];
        lo_nx = {lo[ancho-2:0], 1'b0};
      end
    end
  end

  logic [ancho-1:0] res_lo;
  logic [ancho-1:0] res_hi;
  logic             carry_nx;
  logic             ovf_nx;

  always_comb begin
    res_lo   = lo_nx;
    res_hi   = hi_nx;
    carry_nx = !is_div && (hi_nx != '0);
    ovf_nx   = 1'b0;
`ifdef MULDIV_SIGNED_EN
    if (is_sgn) begin
      carry_nx = 1'b0;
      if (!is_div) begin
        if (neg_q) {res_hi, res_lo} = -{hi_nx, lo_nx};
        ovf_nx = res_hi != {ancho{res_lo[ancho-1]}};
      end else begin
        if (neg_q) res_lo = -lo_nx;
        if (neg_r) res_hi = -hi_nx;
        ovf_nx = ovf_div;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state              <= IDLE;
      cnt                <= '0;
      is_div             <= 1'b0;
      m                  <= '0;
      hi                 <= '0;
      lo                 <= '0;
`ifdef MULDIV_SIGNED_EN
      is_sgn             <= 1'b0;
      neg_q              <= 1'b0;
      neg_r              <= 1'b0;
      ovf_div            <= 1'b0;
`endif
      bus.resultado      <= '0;
      bus.resultado_alto <= '0;
      bus.carryOut       <= 1'b0;
      bus.borrowOut      <= 1'b0;
      bus.overflow       <= 1'b0;
      bus.ocupado        <= 1'b0;
      bus.listo          <= 1'b0;
    end else begin
      bus.listo <= 1'b0;
      unique case (state)
        IDLE: if (bus.inicio) begin
          bus.ocupado <= 1'b1;
          if (bus.operacion[0] && bus.operandoB == '0) begin
            state              <= DONE;
            bus.listo          <= 1'b1;
            bus.resultado      <= '1;
            bus.resultado_alto <= bus.operandoA;
            bus.carryOut       <= 1'b0;
            bus.borrowOut      <= 1'b1;
            bus.overflow       <= 1'b0;
          end else begin
            state  <= CALC;
            cnt    <= '0;
            is_div <= bus.operacion[0];
            m      <= bus.operacion[0] ? b_mag : a_mag;
            lo     <= bus.operacion[0] ? a_mag : b_mag;
            hi     <= '0;
`ifdef MULDIV_SIGNED_EN
            is_sgn  <= sgn_in;
            neg_q   <= a_neg ^ b_neg;
            neg_r   <= a_neg;
            ovf_div <= sgn_in && bus.operacion[0] &&
                       bus.operandoA == MIN_NEG &&
                       bus.operandoB == '1;
`endif
          end
        end
        CALC: begin
          hi  <= hi_nx;
          lo  <= lo_nx;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state              <= DONE;
            bus.listo          <= 1'b1;
            bus.resultado      <= res_lo;
            bus.resultado_alto <= res_hi;
            bus.carryOut       <= carry_nx;
            bus.borrowOut      <= 1'b0;
            bus.overflow       <= ovf_nx;
          end
        end
        DONE: begin
          state       <= IDLE;
          bus.ocupado <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef MULDIV_SIGNED_EN
  logic unused_ok;
  assign unused_ok = &{1'b0, MIN_NEG};
`endif
endmodule
